// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the system SRAM arbiter.
package mem_arb_pkg;

    localparam int unsigned ARB_FIXED    = 0;
    localparam int unsigned ARB_RR       = 1;
    localparam int unsigned MAX_CHANNELS = 8;

    // Index width for n channels; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: first set request at or above base, wrapping modulo CHANNELS.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned CHANNELS = 3
) (
    input  logic [CHANNELS-1:0]            req,
    input  logic [idx_width(CHANNELS)-1:0] base,
    output logic                           valid,
    output logic [idx_width(CHANNELS)-1:0] idx
);

    localparam int unsigned IW   = idx_width(CHANNELS);
    localparam logic [IW:0] CH_W = (IW + 1)'(CHANNELS);

    logic [2*CHANNELS-1:0] dbl;
    logic [CHANNELS-1:0]   rot;
    logic [IW-1:0]         off;
    logic [IW:0]           sum;

    always_comb begin
        // Doubling the vector makes the right shift a rotate by base.
        dbl   = {req, req} >> base;
        rot   = dbl[CHANNELS-1:0];
        valid = |rot;
        off   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IW'(k);
            end
        end
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= CH_W) begin
            sum = sum - CH_W;
        end
        idx = sum[IW-1:0];
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel arbiter sharing the single-port system SRAM between CPU and debug requesters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned CHANNELS     = 3,
    parameter int unsigned AW           = 16,
    parameter int unsigned DW           = 16,
    parameter int unsigned ROUND_ROBIN  = 1,
    parameter int unsigned CH0_OVERRIDE = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [CHANNELS-1:0]    ch_req,
    input  logic [CHANNELS-1:0]    ch_we,
    input  logic [CHANNELS*AW-1:0] ch_addr,
    input  logic [CHANNELS*DW-1:0] ch_wdata,
    output logic [CHANNELS-1:0]    ch_rdy,
    output logic [DW-1:0]          rd_data,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    output logic                   mem_we,
    output logic                   mem_re,
    input  logic [DW-1:0]          mem_rdata,
    output logic [2:0]             last_grant
);

    localparam int unsigned IW = idx_width(CHANNELS);

    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       base, pick_idx, win_idx;
    logic                pick_valid, grant;
    logic [CHANNELS-1:0] ch_rdy_q, ch_rdy_d;
    logic [2:0]          last_grant_q, last_grant_d;

    assign base = (ROUND_ROBIN == ARB_RR) ? ptr_q : '0;

    rr_pick #(
        .CHANNELS(CHANNELS)
    ) u_pick (
        .req  (ch_req),
        .base (base),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    always_comb begin
        win_idx = pick_idx;
        // Debug on channel 0 pre-empts everyone; starving the others is accepted.
        if ((CH0_OVERRIDE != 0) && ch_req[0]) begin
            win_idx = '0;
        end
        grant     = reset_n & pick_valid;
        mem_addr  = ch_addr[win_idx*AW +: AW];
        mem_wdata = ch_wdata[win_idx*DW +: DW];
        mem_we    = grant & ch_we[win_idx];
        mem_re    = grant & ~ch_we[win_idx];

        ch_rdy_d     = '0;
        last_grant_d = last_grant_q;
        ptr_d        = ptr_q;
        if (grant) begin
            ch_rdy_d[win_idx] = 1'b1;
            last_grant_d      = 3'(win_idx);
            ptr_d             = (win_idx == IW'(CHANNELS - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q        <= '0;
            ch_rdy_q     <= '0;
            last_grant_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            ch_rdy_q     <= ch_rdy_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign ch_rdy     = ch_rdy_q;
    assign last_grant = last_grant_q;
    assign rd_data    = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: three arbiter variants (RR+override, RR, fixed) share one stimulus stream.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  ch_req = '0;
    logic [2:0]  ch_we = '0;
    logic [47:0] ch_addr = '0;
    logic [47:0] ch_wdata = '0;

    logic [2:0]  ch_rdy     [3];
    logic [15:0] rd_data    [3];
    logic [15:0] mem_addr   [3];
    logic [15:0] mem_wdata  [3];
    logic        mem_we     [3];
    logic        mem_re     [3];
    logic [15:0] mem_rdata  [3];
    logic [2:0]  last_grant [3];

    int n_vec = 0;
    int n_err = 0;

    // Unit 0: round-robin with override; unit 1: round-robin only; unit 2: fixed priority.
    for (genvar u = 0; u < 3; u++) begin : g_dut
        mem_arbiter #(
            .CHANNELS    (3),
            .AW          (16),
            .DW          (16),
            .ROUND_ROBIN ((u == 2) ? 0 : 1),
            .CH0_OVERRIDE((u == 0) ? 1 : 0)
        ) dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .ch_req    (ch_req),
            .ch_we     (ch_we),
            .ch_addr   (ch_addr),
            .ch_wdata  (ch_wdata),
            .ch_rdy    (ch_rdy[u]),
            .rd_data   (rd_data[u]),
            .mem_addr  (mem_addr[u]),
            .mem_wdata (mem_wdata[u]),
            .mem_we    (mem_we[u]),
            .mem_re    (mem_re[u]),
            .mem_rdata (mem_rdata[u]),
            .last_grant(last_grant[u])
        );
    end

    // Reference winner straight from the selection rules.
    function automatic int pick(input logic [2:0] r, input int p, input int u);
        if (u == 0 && r[0]) return 0;
        for (int i = 0; i < 3; i++) begin
            int c;
            c = (u == 2) ? i : (p + i) % 3;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int u, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s unit%0d t=%0t: got %h expected %h", name, u, $time, act, exp);
        end
    endtask

    // SRAM model per unit: command sampled mid-cycle, executed on the edge.
    logic [15:0] mem [3][65536];
    bit          mem_ready = 1'b0;
    bit          s_we [3];
    bit          s_re [3];
    logic [15:0] s_addr [3];
    logic [15:0] s_wd [3];

    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            s_we[u]   = mem_we[u];
            s_re[u]   = mem_re[u];
            s_addr[u] = mem_addr[u];
            s_wd[u]   = mem_wdata[u];
        end
    end

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int u = 0; u < 3; u++) begin
                for (int a = 0; a < 65536; a++) mem[u][a] = 16'(a) ^ 16'hA5A5;
                mem[u][5] = 16'h1234;
            end
            mem_ready = 1'b1;
        end
        for (int u = 0; u < 3; u++) begin
            if (s_we[u]) mem[u][s_addr[u]] = s_wd[u];
            if (s_re[u]) mem_rdata[u] <= mem[u][s_addr[u]];
        end
    end

    typedef struct {
        int          unit;
        int          ch;
        logic [2:0]  lg;
        bit          rd;
        logic [15:0] data;
    } exp_t;

    exp_t       sbq [$];
    int         mptr [3] = '{0, 0, 0};
    logic [2:0] mlg  [3] = '{3'd0, 3'd0, 3'd0};

    // Model: on every edge decide each unit's grant and queue the expected acknowledge.
    always @(posedge clk) begin
        exp_t e;
        int   w;
        for (int u = 0; u < 3; u++) begin
            e.unit = u;
            e.ch   = -1;
            e.rd   = 1'b0;
            e.data = '0;
            if (!reset_n) begin
                mptr[u] = 0;
                mlg[u]  = 3'd0;
            end else begin
                w = pick(ch_req, mptr[u], u);
                if (w >= 0) begin
                    e.ch    = w;
                    mlg[u]  = 3'(w);
                    mptr[u] = (w + 1) % 3;
                    if (!ch_we[w]) begin
                        e.rd   = 1'b1;
                        e.data = mem[u][ch_addr[w*16 +: 16]];
                    end
                end
            end
            e.lg = mlg[u];
            sbq.push_back(e);
        end
    end

    // Monitor: pop one expectation per unit per cycle, and check the SRAM-side mux.
    always @(negedge clk) begin
        exp_t       e;
        logic [2:0] exp_rdy;
        int         w;
        if (sbq.size() >= 3) begin
            for (int u = 0; u < 3; u++) begin
                e = sbq.pop_front();
                exp_rdy = (reset_n && e.ch >= 0) ? 3'(1 << e.ch) : 3'd0;
                chk("ch_rdy", u, 32'(ch_rdy[u]), 32'(exp_rdy));
                chk("last_grant", u, 32'(last_grant[u]), reset_n ? 32'(e.lg) : 32'd0);
                if (reset_n && e.rd) chk("rd_data", u, 32'(rd_data[u]), 32'(e.data));
            end
        end
        for (int u = 0; u < 3; u++) begin
            w = reset_n ? pick(ch_req, mptr[u], u) : -1;
            chk("mem_we", u, 32'(mem_we[u]), 32'(w >= 0 && ch_we[w] == 1'b1));
            chk("mem_re", u, 32'(mem_re[u]), 32'(w >= 0 && ch_we[w] == 1'b0));
            if (w >= 0) begin
                chk("mem_addr", u, 32'(mem_addr[u]), 32'(ch_addr[w*16 +: 16]));
                chk("mem_wdata", u, 32'(mem_wdata[u]), 32'(ch_wdata[w*16 +: 16]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with everyone requesting reads.
        ch_req  = 3'b111;
        ch_we   = 3'b000;
        ch_addr = {16'h0003, 16'h0002, 16'h0001};
        step(3);
        reset_n = 1'b1;
        // Everyone holds: fairness for RR units, override for unit 0.
        step(6);
        // Channels 1 and 2 only: fixed unit always picks 1.
        ch_req = 3'b110;
        step(5);
        // Single reader on channel 1 at 0x0005.
        ch_req = 3'b010;
        ch_addr[16 +: 16] = 16'h0005;
        step(1);
        ch_req = 3'b000;
        step(2);
        // Channel 0 writes 0xBEEF to 0x8010 while 1 and 2 contend, then steps away.
        ch_addr[0 +: 16]  = 16'h8010;
        ch_wdata[0 +: 16] = 16'hBEEF;
        ch_we  = 3'b001;
        ch_req = 3'b111;
        step(2);
        ch_req = 3'b110;
        step(4);
        // Reset lands right after a grant; the held request is reissued.
        ch_req = 3'b010;
        ch_we  = 3'b000;
        step(1);
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(3);
        // Randomised traffic; a requester only changes once unit 0 acknowledges it.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (!ch_req[k] || ch_rdy[0][k]) begin
                    ch_req[k]          = ($urandom_range(0, 3) != 0);
                    ch_we[k]           = 1'($urandom_range(0, 1));
                    ch_addr[k*16 +: 16]  = 16'($urandom_range(0, 31));
                    ch_wdata[k*16 +: 16] = 16'($urandom);
                end
            end
            step(1);
        end
        ch_req = 3'b000;
        step(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-channel arbiter for the single-port system SRAM. It lets the CPU instruction port, the CPU data port and the debug interface share one memory. The ready signals are real: each one is a registered acknowledgement of a request granted on the previous edge. It sits between the requesters and the `sram` read/write port and runs in the system clock domain.

## Interface
- `CHANNELS`, 3: number of requesters, 2..8; channel 0 is the lowest index.
- `AW`, 16: address width.
- `DW`, 16: data width.
- `ROUND_ROBIN`, 1: 1 = rotating priority; 0 = fixed priority, lowest index wins.
- `CH0_OVERRIDE`, 1: 1 = channel 0 (debug) wins whenever it requests, in either mode.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ch_req` in CHANNELS: per-channel request.
- `ch_we` in CHANNELS: per-channel direction; 1 = write, 0 = read.
- `ch_addr` in CHANNELS*AW: packed addresses; channel k occupies `[k*AW +: AW]`.
- `ch_wdata` in CHANNELS*DW: packed write data, same packing as `ch_addr`.
- `ch_rdy` out CHANNELS: one-hot completion strobe, registered.
- `rd_data` out DW: read data; valid only to the channel whose `ch_rdy` is high.
- `mem_addr` out AW: combinational address to the SRAM.
- `mem_wdata` out DW: combinational write data to the SRAM.
- `mem_we` out 1: SRAM write enable.
- `mem_re` out 1: SRAM read enable.
- `mem_rdata` in DW: SRAM registered read data, one-cycle latency.
- `last_grant` out 3: registered index of the most recent grant, for debug.

## Operation
- Each cycle, the arbiter combinationally picks at most one channel from those with `ch_req` high.
- The winner's `ch_addr` and `ch_wdata` drive `mem_addr` and `mem_wdata`.
- `mem_we` = winner's `ch_we`; `mem_re` = NOT the winner's `ch_we`. Both are 0 when there is no winner.
- Winner selection:
  - `CH0_OVERRIDE`=1 and `ch_req[0]` high: channel 0 wins.
  - Otherwise, `ROUND_ROBIN`=0: the lowest requesting index wins.
  - Otherwise, `ROUND_ROBIN`=1: the first requesting index at or above `ptr` wins, searching with wrap modulo CHANNELS.
- Round-robin pointer:
  - `ptr` is a register of width clog2(CHANNELS), reset value 0.
  - On a grant to channel k, `ptr` <= (k+1) mod CHANNELS.
  - With no grant, `ptr` holds.
  - An override grant to channel 0 also updates `ptr`.
- Acknowledge:
  - On each edge, `ch_rdy` <= one-hot of the winner, or 0 with no winner.
  - `last_grant` <= the winner's index.
- `rd_data` = `mem_rdata`, passed through. It is meaningful only for reads; for a write completion its value is don't-care.
- Request protocol:
  - A requester keeps its request, direction, address and data stable until it sees its own `ch_rdy`.
  - In the cycle its `ch_rdy` is high, it may change request, direction, address and data combinationally for its next transaction.
  - A request still present in that cycle is a new transaction.
  - A requester that holds its request and wins every cycle therefore gets `ch_rdy` every cycle.
- A losing requester simply waits; it gets no other signal.
- Reset:
  - While `reset_n` is low: `ch_rdy`=0, `last_grant`=0, `ptr`=0, and `mem_we`=`mem_re`=0 regardless of requests.
  - A grant issued on the edge before reset asserts gets no `ch_rdy`; the requester reissues it.

## Timing
- Latency is one cycle: a request granted at edge E gets `ch_rdy` high during E..E+1.
- Read data is valid in that same window.
- Throughput is one transaction per cycle across all channels.
- With `ROUND_ROBIN`=1 and all channels requesting, each channel gets at least one grant in every CHANNELS consecutive cycles.
- Channel 0 under override can starve all other channels; this is intentional.
- The selection path is the critical path: request, through the picker and the address mux, to the SRAM.

## Structure
- Package `mem_arb_pkg` holds:
  - the `ROUND_ROBIN` mode constants (`ARB_FIXED`=0, `ARB_RR`=1);
  - the `MAX_CHANNELS`=8 constant;
  - a function for the index width.
- Sub-module `rr_pick`:
  - Parameter CHANNELS.
  - Inputs: request vector, base index.
  - Outputs: `valid`, `idx`.
  - Purely combinational rotate / priority-encode / unrotate.
  - Fixed mode uses base 0.
- Top level holds the override mux, the `ptr`, `ch_rdy` and `last_grant` registers, and the data muxes.

## Test plan
- Reset: hold `reset_n` low with all `ch_req`=1 -> `ch_rdy`=0, `mem_we`=`mem_re`=0. Release -> the first grant goes to channel 0 at the next edge.
- Single reader: channel 1 reads address 0x0005, which holds 0x1234 -> `mem_re`=1 and `mem_addr`=0x0005; one cycle later `ch_rdy`=3'b010 and `rd_data`=0x1234.
- Round-robin fairness: CHANNELS=3, `CH0_OVERRIDE`=0, all channels hold their request -> `ch_rdy` sequence is 001, 010, 100, 001, … with no gaps.
- Fixed mode: `ROUND_ROBIN`=0, channels 1 and 2 request continuously -> channel 1 is acknowledged every cycle and channel 2 never is.
- Override: channel 0 writes 0xBEEF to 0x8010 while channels 1 and 2 request -> channel 0 wins, `mem_we`=1, `ch_rdy`=001. When channel 0 drops its request, the grant resumes at `ptr`=1.
- Reset mid-transaction: assert `reset_n` low on the edge right after a grant -> no `ch_rdy` appears. After release, the held request is granted and acknowledged normally.
